inst_encoder_loader: RTL

Inverse of the instruction decoder. Takes decoded instruction fields over a valid/ready stream and packs them into 16-bit instruction words using the processor's opcode formats. Encoded words are buffered in a small FIFO. The FIFO drains into the instruction-memory write port, with an auto-incrementing address. The block sits between the program source (testbench or boot controller) and instruction memory.

---
 rtl/inst_encoder_loader_if.sv | 34 +++
 rtl/inst_encoder_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/inst_encoder_loader_if.sv
// Stream bus for inst_encoder_loader: decoded-field tuples in, instruction-memory writes out.
// Both sides use valid/ready: a transfer happens on a rising edge where valid (in_valid / mem_we) and ready (in_ready / mem_ready) are both 1.
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [2:0]        in_rd;
    logic [2:0]        in_rs;
    logic [2:0]        in_rt;
    logic [2:0]        in_func;
    logic [2:0]        in_shamt;
    logic [5:0]        in_const;
    logic [5:0]        in_adds2;
    logic [8:0]        in_jaddr;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_func, in_shamt,
               in_const, in_adds2, in_jaddr, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_func, in_shamt,
               in_const, in_adds2, in_jaddr, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words, buffers them, and streams them into instruction memory.
// Optional macro FIELD_CHECK_EN rejects tuples whose discarded fields are nonzero and pulses err.
module inst_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    inst_encoder_loader_if.slave     bus,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                FILL_W  = PTR_W + 1;
    localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    // Each entry is {last, word}
    logic [16:0]       fifo_q [DEPTH];
    logic [16:0]       fifo_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic [15:0]       word;
    logic [16:0]       head;
    logic              accept, reject, push, pop, flush;

    always_comb begin
        word = {bus.in_op, 12'h000};
        case (bus.in_op)
            4'd0:             word[11:0] = {bus.in_rd, bus.in_rs, bus.in_rt, bus.in_func};
            4'd1, 4'd2:       word[11:0] = {bus.in_rd, bus.in_rs, 3'b000, bus.in_shamt};
            4'd3, 4'd4:       word[11:0] = {bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt};
            4'd5, 4'd7, 4'd8: word[11:0] = {bus.in_rd, bus.in_rs, bus.in_const};
            4'd6:             word[11:0] = {bus.in_rd, 3'b000, bus.in_const};
            4'd9:             word[11:0] = {bus.in_jaddr, 3'b000};
            default:          word[11:0] = {bus.in_rd, bus.in_rs, bus.in_adds2};
        endcase
    end

    // Ready depends only on the registered count, so a same-cycle pop never opens a full FIFO
    assign bus.in_ready  = fill_q < DEPTH_F;
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && !reject;
    assign head          = fifo_q[rd_ptr_q];
    assign bus.mem_we    = fill_q != '0;
    assign pop           = bus.mem_we && bus.mem_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = head[15:0];
    assign done          = done_q;
    assign fill          = fill_q;

`ifdef FIELD_CHECK_EN
    logic err_q, err_d, pend_q, pend_d;

    always_comb begin
        reject = 1'b0;
        case (bus.in_op)
            4'd1, 4'd2: reject = bus.in_rt != '0;
            4'd6:       reject = bus.in_rs != '0;
            4'd9:       reject = (bus.in_rd != '0) || (bus.in_rs != '0);
            4'd3, 4'd4: reject = 1'b0;
            default:    reject = bus.in_shamt != '0;
        endcase
    end

    // A rejected last tuple still ends the program, once everything before it is written
    assign flush = pend_q && (fill_q == '0) && !push;

    always_comb begin
        err_d  = accept && reject;
        pend_d = pend_q;
        if (accept && reject && bus.in_last) pend_d = 1'b1;
        else if (flush)                      pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    assign err = err_q;
`else
    assign reject = 1'b0;
    assign flush  = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        if (push) begin
            fifo_d[wr_ptr_q] = {bus.in_last, word};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = head[16] ? BASE : addr_q + ADDR_W'(1);
            done_d   = head[16];
        end else if (flush) begin
            addr_d = BASE;
            done_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            addr_q   <= BASE;
            done_q   <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
        end
    end
endmodule
